// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: taken-branch flushes, one-bubble
// load-use stalls and multi-cycle mult/div occupancy of EX.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; branch flush, mdu entry or load-use bubble
// MDU_WAIT | mult/div still occupying EX; cnt counts remaining cycles
module hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ifid_instr,
    input  logic [31:0] idex_instr,
    input  logic        branch_taken,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        mdu_busy,
    output logic [1:0]  state,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MDU_WAIT = 2'b01
    } state_t;

    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 2);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 2);

    state_t     cur_state, nxt_state;
    logic [7:0] cnt, nxt_cnt;

    logic [5:0] idex_op, idex_funct, ifid_op;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       is_load, is_mult, is_div, is_mdu;
    logic       uses_rs, uses_rt, load_use;
    logic       unused_bits;

    assign idex_op    = idex_instr[31:26];
    assign idex_funct = idex_instr[5:0];
    assign idex_rt    = idex_instr[20:16];
    assign ifid_op    = ifid_instr[31:26];
    assign ifid_rs    = ifid_instr[25:21];
    assign ifid_rt    = ifid_instr[20:16];
    assign unused_bits = ^{idex_instr[25:21], idex_instr[15:6], ifid_instr[15:0]};

    assign is_load = (idex_op == 6'b100011) || (idex_op == 6'b100000) ||
                     (idex_op == 6'b100100);
    assign is_mult = (idex_op == 6'b000000) &&
                     ((idex_funct == 6'b011000) || (idex_funct == 6'b011001));
    assign is_div  = (idex_op == 6'b000000) &&
                     ((idex_funct == 6'b011010) || (idex_funct == 6'b011011));
    assign is_mdu  = is_mult || is_div;

    // Shifts count as reading rs; the occasional extra bubble is accepted.
    assign uses_rs = (ifid_op != 6'b000010) && (ifid_op != 6'b000011);
    assign uses_rt = (ifid_op == 6'b000000) || (ifid_op == 6'b000100) ||
                     (ifid_op == 6'b000101) || (ifid_op == 6'b101011) ||
                     (ifid_op == 6'b101000) || (ifid_op == 6'b101001);

    assign load_use = is_load && (idex_rt != 5'd0) &&
                      ((uses_rs && (idex_rt == ifid_rs)) ||
                       (uses_rt && (idex_rt == ifid_rt)));

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        mdu_busy   = 1'b0;
        nxt_state  = cur_state;
        nxt_cnt    = cnt;
        if (!rst_n) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            nxt_state = RUN;
            nxt_cnt   = 8'd0;
        end else begin
            case (cur_state)
                RUN: begin
                    if (branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (is_mdu) begin
                        pc_en     = 1'b0;
                        ifid_en   = 1'b0;
                        idex_en   = 1'b0;
                        mdu_busy  = 1'b1;
                        nxt_cnt   = is_div ? DIV_LOAD : MULT_LOAD;
                        nxt_state = MDU_WAIT;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    // EX holds the mult/div, so branch_taken cannot be live here.
                    mdu_busy = 1'b1;
                    if (cnt != 8'd0) begin
                        pc_en   = 1'b0;
                        ifid_en = 1'b0;
                        idex_en = 1'b0;
                        nxt_cnt = cnt - 8'd1;
                    end else begin
                        nxt_state = RUN;
                    end
                end
                default: begin
                    nxt_state = RUN;
                    nxt_cnt   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state   <= RUN;
            cnt         <= 8'd0;
            stall_count <= 16'd0;
        end else begin
            cur_state <= nxt_state;
            cnt       <= nxt_cnt;
            if (!pc_en && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;
        end
    end

    assign state = cur_state;

endmodule
